// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pkg
// Description : Shared types and constants for the instruction fetch stage.
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] PC_STEP = 32'd4;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
    } fetch_entry_t;

    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
        return {pc[XLEN-1:2], 2'b00};
    endfunction

endpackage

`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
// Module      : fetch_fifo
// Description : Synchronous FIFO of fetch entries with flush and head output.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         i_push,
    input  logic                         i_pop,
    input  logic                         i_flush,
    input  fetch_entry_t                 i_data,
    output fetch_entry_t                 o_head,
    output logic [$clog2(DEPTH+1)-1:0]   o_count
);

    localparam int c_CW = $clog2(DEPTH + 1);
    localparam int c_PW = $clog2(DEPTH);

    fetch_entry_t    r_mem [DEPTH];
    logic [c_PW-1:0] r_wptr;
    logic [c_PW-1:0] r_rptr;
    logic [c_CW-1:0] r_count;

    // Storage has no reset; only the pointers and count qualify its contents.
    always_ff @(posedge clk) begin
        if (i_push && !i_flush) begin
            r_mem[r_wptr] <= i_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (i_flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (i_push) begin
                r_wptr <= r_wptr + c_PW'(1);
            end
            if (i_pop) begin
                r_rptr <= r_rptr + c_PW'(1);
            end
            r_count <= r_count + c_CW'(i_push) - c_CW'(i_pop);
        end
    end

    assign o_head  = r_mem[r_rptr];
    assign o_count = r_count;

endmodule

`default_nettype wire

// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch
// Description : Credit-based instruction fetch with prefetch queue and
//               redirect squash. Optional macro IFETCH_BYPASS_EN enables a
//               zero-latency path from memory response to the core.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch
    import fetch_pkg::*;
#(
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] pc
);

    localparam int c_CW = $clog2(DEPTH + 1);
    localparam int c_DW = c_CW + 1;

    logic [XLEN-1:0] r_fpc;
    logic [XLEN-1:0] r_rpc;
    logic [c_CW-1:0] r_outstanding;
    logic [c_DW-1:0] r_discard;

    logic [c_CW-1:0] w_count;
    fetch_entry_t    w_head;
    fetch_entry_t    w_rsp_entry;
    logic            w_credits_ok;
    logic            w_accept;
    logic            w_drop;
    logic            w_keep;
    logic            w_bypass;
    logic            w_push;
    logic            w_pop;
    logic            w_nonempty;

    assign w_credits_ok   = ({1'b0, r_outstanding} + {1'b0, w_count}) < c_DW'(DEPTH);
    assign imem_req_valid = reset && w_credits_ok && !redirect_valid;
    assign imem_addr      = r_fpc;
    assign w_accept       = imem_req_valid && imem_req_ready;

    assign w_drop      = (r_discard != '0);
    assign w_keep      = imem_rsp_valid && !w_drop && !redirect_valid;
    assign w_rsp_entry = '{instr: imem_rsp_data, pc: r_rpc};
    assign w_nonempty  = (w_count != '0);

`ifdef IFETCH_BYPASS_EN
    assign w_bypass = !w_nonempty && w_keep;
`else
    assign w_bypass = 1'b0;
`endif

    assign instr_valid = w_nonempty || w_bypass;
    assign w_pop       = w_nonempty && instr_ready && !redirect_valid;
    assign w_push      = w_keep && !(w_bypass && instr_ready);

    always_comb begin
        instr = '0;
        pc    = '0;
        if (w_nonempty) begin
            instr = w_head.instr;
            pc    = w_head.pc;
        end else if (w_bypass) begin
            instr = w_rsp_entry.instr;
            pc    = w_rsp_entry.pc;
        end
    end

    // Squashed reads move from the live count into the discard count, so
    // credits only ever cover reads that will land in the queue.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_fpc         <= RESET_PC;
            r_rpc         <= RESET_PC;
            r_outstanding <= '0;
            r_discard     <= '0;
        end else if (redirect_valid) begin
            r_fpc         <= align_pc(redirect_pc);
            r_rpc         <= align_pc(redirect_pc);
            r_outstanding <= '0;
            r_discard     <= c_DW'(r_outstanding) + r_discard - c_DW'(imem_rsp_valid);
        end else begin
            if (w_accept) begin
                r_fpc <= r_fpc + PC_STEP;
            end
            if (imem_rsp_valid && w_drop) begin
                r_discard <= r_discard - c_DW'(1);
            end
            if (imem_rsp_valid && !w_drop) begin
                r_rpc <= r_rpc + PC_STEP;
            end
            r_outstanding <= r_outstanding + c_CW'(w_accept)
                           - c_CW'(imem_rsp_valid && !w_drop);
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (reset),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (redirect_valid),
        .i_data  (w_rsp_entry),
        .o_head  (w_head),
        .o_count (w_count)
    );

endmodule

`default_nettype wire

// File: tb/tb_instr_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_fetch
// Description : Randomised self-checking bench for instr_fetch against a
//               queue-based reference model and an in-order memory model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_fetch;
    import fetch_pkg::*;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
`ifdef IFETCH_BYPASS_EN
    localparam int FIRST_LAT = 1;
`else
    localparam int FIRST_LAT = 2;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [31:0] instr;
    logic [31:0] pc;

    instr_fetch #(
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_addr      (imem_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .pc             (pc)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] addr; int due; } mreq_t;
    typedef struct { logic [31:0] pc; bit drop; } infl_t;
    typedef struct { logic [31:0] pc; int cyc; } cons_t;

    mreq_t        mq[$];
    infl_t        infl[$];
    fetch_entry_t q[$];
    cons_t        cons[$];
    logic [31:0]  accs[$];
    logic [31:0]  m_fpc = RESET_PC;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int r0     = 0;
    int lat = 1, p_rdy = 100, p_ir = 100, p_redir = 0;
    int ovr_ir = -1;
    bit ovr_redir = 1'b0;
    logic [31:0] ovr_rpc = '0;
    logic last_req, last_iv, last_rsp;
    logic [31:0] last_addr;

    function automatic logic [31:0] memdata(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hC3A5_5A3C;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // One clock cycle: drive at negedge+1, check at negedge+2, update at posedge.
    task automatic cycle();
        int           live;
        bit           has_drop, e_req, e_iv, byp, acc_dut, keep;
        fetch_entry_t head;
        infl_t        f;
        logic [31:0]  acc_addr;
        imem_req_ready = ($urandom_range(99) < p_rdy);
        instr_ready    = (ovr_ir >= 0) ? (ovr_ir != 0) : ($urandom_range(99) < p_ir);
        if (ovr_redir) begin
            redirect_valid = 1'b1;
            redirect_pc    = ovr_rpc;
        end else begin
            redirect_valid = ($urandom_range(99) < p_redir);
            redirect_pc    = $urandom;
        end
        imem_rsp_valid = (mq.size() > 0) && (mq[0].due <= cyc);
        imem_rsp_data  = imem_rsp_valid ? memdata(mq[0].addr) : $urandom;
        #1;
        live = 0;
        has_drop = 1'b0;
        foreach (infl[i]) begin
            if (infl[i].drop) has_drop = 1'b1;
            else live++;
        end
        e_req = ((live + q.size()) < DEPTH) && !redirect_valid;
        byp   = 1'b0;
`ifdef IFETCH_BYPASS_EN
        byp = (q.size() == 0) && !has_drop && !redirect_valid && imem_rsp_valid && (infl.size() > 0);
`endif
        e_iv = (q.size() != 0) || byp;
        head.instr = '0;
        head.pc    = '0;
        if (q.size() != 0) begin
            head = q[0];
        end else if (byp) begin
            head.instr = imem_rsp_data;
            head.pc    = infl[0].pc;
        end
        chk("req_valid", imem_req_valid, e_req);
        if (e_req) chk("imem_addr", imem_addr, m_fpc);
        chk("instr_valid", instr_valid, e_iv);
        if (e_iv) begin
            chk("instr", instr, head.instr);
            chk("pc", pc, head.pc);
        end
        last_req  = imem_req_valid;
        last_addr = imem_addr;
        last_iv   = instr_valid;
        last_rsp  = imem_rsp_valid;
        acc_dut   = imem_req_valid && imem_req_ready;
        acc_addr  = imem_addr;
        if (acc_dut) accs.push_back(acc_addr);
        @(posedge clk);
        if (imem_rsp_valid) void'(mq.pop_front());
        if (acc_dut) mq.push_back('{acc_addr, cyc + lat});
        keep = 1'b0;
        if (imem_rsp_valid && infl.size() > 0) begin
            f    = infl.pop_front();
            keep = !f.drop && !redirect_valid;
        end
        if (redirect_valid) begin
            q.delete();
            foreach (infl[i]) infl[i].drop = 1'b1;
            m_fpc = redirect_pc & ~32'h3;
        end else begin
            if (e_iv && instr_ready) begin
                cons.push_back('{head.pc, cyc});
                if (q.size() > 0) void'(q.pop_front());
            end
            if (keep && !(byp && instr_ready)) begin
                fetch_entry_t e;
                e.instr = imem_rsp_data;
                e.pc    = f.pc;
                q.push_back(e);
            end
            if (e_req && imem_req_ready) begin
                infl.push_back('{m_fpc, 1'b0});
                m_fpc = m_fpc + 32'd4;
            end
        end
        cyc++;
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset(input int hold);
        #2;
        reset = 1'b0;
        #1;
        chk("async instr_valid", instr_valid, 1'b0);
        chk("reset req_valid", imem_req_valid, 1'b0);
        chk("reset instr", instr, 32'h0);
        chk("reset pc", pc, 32'h0);
        redirect_valid = 1'b0;
        imem_rsp_valid = 1'b0;
        instr_ready    = 1'b0;
        imem_req_ready = 1'b0;
        q.delete(); infl.delete(); mq.delete(); cons.delete(); accs.delete();
        m_fpc = RESET_PC;
        repeat (hold) @(posedge clk);
        @(negedge clk);
        #1;
        reset = 1'b1;
        r0 = cyc;
    endtask

    initial begin
        // Streaming from reset
        do_reset(2);
        lat = 1; p_rdy = 100; p_ir = 100; p_redir = 0;
        repeat (8) cycle();
        chk("s1 consumed count", cons.size() >= 3, 1'b1);
        chk("s1 first pc", cons[0].pc, 32'h0);
        chk("s1 first latency", cons[0].cyc - r0, FIRST_LAT);
        chk("s1 second pc", cons[1].pc, 32'h4);
        chk("s1 third pc", cons[2].pc, 32'h8);
        chk("s1 back-to-back", cons[2].cyc - cons[1].cyc, 1);
        chk("s1 addr0", accs[0], 32'h0);
        chk("s1 addr2", accs[2], 32'h8);

        // Core stalled: credits cap requests at DEPTH
        do_reset(2);
        ovr_ir = 0;
        repeat (10) cycle();
        chk("s2 requests while stalled", accs.size(), DEPTH);
        chk("s2 req_valid low", last_req, 1'b0);
        ovr_ir = 1;
        repeat (6) cycle();
        chk("s2 consumed count", cons.size() >= 4, 1'b1);
        chk("s2 pc0", cons[0].pc, 32'h0);
        chk("s2 pc1", cons[1].pc, 32'h4);
        chk("s2 pc2", cons[2].pc, 32'h8);
        chk("s2 pc3", cons[3].pc, 32'hC);
        ovr_ir = -1;

        // Redirect with two slow reads in flight
        do_reset(2);
        lat = 3;
        repeat (2) cycle();
        chk("s3 outstanding", accs.size(), 2);
        ovr_redir = 1'b1; ovr_rpc = 32'h0000_0100;
        cycle();
        ovr_redir = 1'b0;
        cons.delete();
        repeat (12) cycle();
        chk("s3 first pc after redirect", cons[0].pc, 32'h100);
        chk("s3 second pc after redirect", cons[1].pc, 32'h104);

        // Redirect colliding with a response and a pop
        do_reset(2);
        lat = 1;
        repeat (5) cycle();
        ovr_redir = 1'b1; ovr_rpc = 32'h0000_0200;
        cycle();
        chk("s4 rsp in redirect cycle", last_rsp, 1'b1);
        chk("s4 head valid in redirect cycle", last_iv, 1'b1);
        ovr_redir = 1'b0;
        cycle();
        chk("s4 queue empty after redirect", last_iv, 1'b0);
        chk("s4 req after redirect", last_req, 1'b1);
        chk("s4 addr after redirect", last_addr, 32'h200);

        // Fetch PC wrap
        ovr_redir = 1'b1; ovr_rpc = 32'hFFFF_FFFE;
        cycle();
        ovr_redir = 1'b0;
        accs.delete();
        repeat (4) cycle();
        chk("s5 aligned target", accs[0], 32'hFFFF_FFFC);
        chk("s5 wrapped addr", accs[1], 32'h0000_0000);

        // Reset with entries queued
        do_reset(2);
        ovr_ir = 0;
        repeat (4) cycle();
        chk("s6 model queued", q.size(), 3);
        chk("s6 valid before reset", instr_valid, 1'b1);
        do_reset(2);
        ovr_ir = -1;
        repeat (3) cycle();
        chk("s6 restart addr", accs[0], RESET_PC);

        // Randomised phases
        for (int ph = 0; ph < 6; ph++) begin
            lat     = 1 + (ph % 3);
            p_rdy   = 50 + $urandom_range(50);
            p_ir    = 30 + $urandom_range(70);
            p_redir = (ph == 0) ? 0 : $urandom_range(8);
            repeat (400) cycle();
            if (ph == 3) do_reset(1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
